// File: rtl/im_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : im_fetch_ctrl
//  Purpose  : Instruction-fetch sequencer for the single-cycle MIPS core.
//             Owns the program counter that addresses the instruction memory,
//             registers the returned word for decode, applies jump/branch
//             redirects and stalls, stops on a halt word and counts issues.
//  Ports    :
//    clk_i          rising-edge clock
//    rst_ni         asynchronous active-low reset
//    start_i        leave IDLE / HALT (level, sampled each edge)
//    stall_i        hold PC and issued instruction this cycle
//    jmp_i          redirect to jmp_target_i (highest priority)
//    jmp_target_i   jump word address
//    br_taken_i     redirect to br_target_i
//    br_target_i    branch word address
//    imrd_i         instruction memory read data (combinational from ima_o)
//    ima_o          instruction memory word address (PC register)
//    instr_o        registered instruction to decode
//    instr_valid_o  instr_o holds a newly issued instruction this cycle
//    halted_o       controller is in HALT
//    issue_cnt_o    instructions issued since reset/restart, saturating
//  Revision : 1.0  initial release
// ============================================================================
module im_fetch_ctrl #(
    parameter int          WL        = 32,
    parameter int          AW        = 6,
    parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
    input  logic          stall_i,
    input  logic          jmp_i,
    input  logic [AW-1:0] jmp_target_i,
    input  logic          br_taken_i,
    input  logic [AW-1:0] br_target_i,
    input  logic [WL-1:0] imrd_i,
    output logic [AW-1:0] ima_o,
    output logic [WL-1:0] instr_o,
    output logic          instr_valid_o,
    output logic          halted_o,
    output logic [15:0]   issue_cnt_o
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q,    pc_d;
    logic [WL-1:0] instr_q, instr_d;
    logic          valid_q, valid_d;
    logic [15:0]   cnt_q,   cnt_d;

    logic          is_halt_word;

    // Compare against the halt encoding resized to the instruction width.
    assign is_halt_word = (imrd_i == HALT_WORD[WL-1:0]);

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            instr_q <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        valid_d = 1'b0;
        cnt_d   = cnt_q;

        unique case (state_q)
            ST_IDLE: begin
                pc_d = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                // A stall freezes everything; redirects are deliberately
                // dropped here because the requester keeps them asserted.
                if (!stall_i) begin
                    if (is_halt_word) begin
                        // Halt wins over any redirect; PC stays on the halt word.
                        state_d = ST_HALT;
                        instr_d = imrd_i;
                    end else begin
                        // The current word always issues, even alongside a
                        // redirect: there is no flush of the fetched word.
                        instr_d = imrd_i;
                        valid_d = 1'b1;
                        if (cnt_q != 16'hFFFF) begin
                            cnt_d = cnt_q + 16'd1;
                        end
                        if (jmp_i) begin
                            pc_d = jmp_target_i;
                        end else if (br_taken_i) begin
                            pc_d = br_target_i;
                        end else begin
                            pc_d = pc_q + {{(AW-1){1'b0}}, 1'b1};
                        end
                    end
                end
            end

            ST_HALT: begin
                if (start_i) begin
                    state_d = ST_IDLE;
                    pc_d    = '0;
                    cnt_d   = '0;
                    instr_d = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                pc_d    = '0;
            end
        endcase
    end

    assign ima_o         = pc_q;
    assign instr_o       = instr_q;
    assign instr_valid_o = valid_q;
    assign halted_o      = (state_q == ST_HALT);
    assign issue_cnt_o   = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_im_fetch_ctrl
//  Purpose  : Self-checking bench for im_fetch_ctrl: a table of directed
//             vectors, hand-written corner sequences and a randomized run
//             checked against a behavioural fetch model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_im_fetch_ctrl;

    localparam logic [31:0] HALT = 32'hFFFF_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        jmp_i = 1'b0;
    logic [5:0]  jmp_target_i = '0;
    logic        br_taken_i = 1'b0;
    logic [5:0]  br_target_i = '0;
    logic [31:0] imrd_i;
    logic [5:0]  ima_o;
    logic [31:0] instr_o;
    logic        instr_valid_o;
    logic        halted_o;
    logic [15:0] issue_cnt_o;

    logic [31:0] mem [64];

    assign imrd_i = mem[ima_o];

    always #5 clk_i = ~clk_i;

    im_fetch_ctrl #(.WL(32), .AW(6), .HALT_WORD(HALT)) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .start_i       (start_i),
        .stall_i       (stall_i),
        .jmp_i         (jmp_i),
        .jmp_target_i  (jmp_target_i),
        .br_taken_i    (br_taken_i),
        .br_target_i   (br_target_i),
        .imrd_i        (imrd_i),
        .ima_o         (ima_o),
        .instr_o       (instr_o),
        .instr_valid_o (instr_valid_o),
        .halted_o      (halted_o),
        .issue_cnt_o   (issue_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ------------------------------------------------------------------------
    // Behavioural model: mode 0 idle, 1 running, 2 halted.
    // ------------------------------------------------------------------------
    int          m_mode;
    int          m_pc;
    logic [31:0] m_instr;
    bit          m_valid;
    int          m_cnt;

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_instr = 0; m_valid = 0; m_cnt = 0;
    endtask

    task automatic model_step(input bit st, input bit sl, input bit j, input int jt,
                              input bit b, input int bt);
        logic [31:0] w;
        m_valid = 0;
        if (m_mode == 0) begin
            m_pc = 0;
            if (st) m_mode = 1;
        end else if (m_mode == 1) begin
            if (!sl) begin
                w = mem[m_pc];
                m_instr = w;
                if (w == HALT) begin
                    m_mode = 2;
                end else begin
                    m_valid = 1;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                    if (j)      m_pc = jt;
                    else if (b) m_pc = bt;
                    else        m_pc = (m_pc + 1) % 64;
                end
            end
        end else begin
            if (st) begin
                m_mode = 0; m_pc = 0; m_cnt = 0; m_instr = 0;
            end
        end
    endtask

    task automatic check(input string nm, input logic [5:0] e_ima, input logic [31:0] e_instr,
                         input logic e_valid, input logic e_halted, input logic [15:0] e_cnt);
        n_checks++;
        if (ima_o !== e_ima || instr_o !== e_instr || instr_valid_o !== e_valid ||
            halted_o !== e_halted || issue_cnt_o !== e_cnt) begin
            n_errors++;
            $display("FAIL %s: got ima=%0d instr=%h valid=%b halted=%b cnt=%0d, want ima=%0d instr=%h valid=%b halted=%b cnt=%0d",
                     nm, ima_o, instr_o, instr_valid_o, halted_o, issue_cnt_o,
                     e_ima, e_instr, e_valid, e_halted, e_cnt);
        end
    endtask

    task automatic check_model(input string nm);
        check(nm, 6'(m_pc), m_instr, m_valid, (m_mode == 2), 16'(m_cnt));
    endtask

    // One clock with the given inputs, checked against the model afterwards.
    task automatic cycle(input bit st, input bit sl, input bit j, input int jt,
                         input bit b, input int bt, input string nm);
        start_i = st; stall_i = sl; jmp_i = j; jmp_target_i = 6'(jt);
        br_taken_i = b; br_target_i = 6'(bt);
        model_step(st, sl, j, jt, b, bt);
        @(posedge clk_i);
        #1;
        check_model(nm);
    endtask

    task automatic do_reset();
        start_i = 0; stall_i = 0; jmp_i = 0; br_taken_i = 0;
        jmp_target_i = '0; br_target_i = '0;
        rst_ni = 0;
        model_reset();
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        rst_ni = 1;
        #1;
    endtask

    // ------------------------------------------------------------------------
    // Directed vector table
    // ------------------------------------------------------------------------
    typedef struct {
        logic        st, sl, j;
        logic [5:0]  jt;
        logic        b;
        logic [5:0]  bt;
        logic [5:0]  e_ima;
        logic [31:0] e_instr;
        logic        e_valid, e_halted;
        logic [15:0] e_cnt;
    } vec_t;

    function automatic vec_t mk(logic st, logic sl, logic j, logic [5:0] jt, logic b,
                                logic [5:0] bt, logic [5:0] ima, logic [31:0] ins,
                                logic v, logic h, logic [15:0] c);
        vec_t r;
        r.st = st; r.sl = sl; r.j = j; r.jt = jt; r.b = b; r.bt = bt;
        r.e_ima = ima; r.e_instr = ins; r.e_valid = v; r.e_halted = h; r.e_cnt = c;
        return r;
    endfunction

    vec_t tbl [13];

    initial begin
        // mem[k] = 0x100+k, halt word at 12
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
        mem[12] = HALT;
        //            st sl j  jt     b  bt     ima    instr         v  h  cnt
        tbl[0]  = mk(1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  32'h0,        0, 0, 16'd0);
        tbl[1]  = mk(0, 0, 0, 6'd0,  0, 6'd0,  6'd1,  32'h100,      1, 0, 16'd1);
        tbl[2]  = mk(0, 0, 0, 6'd0,  0, 6'd0,  6'd2,  32'h101,      1, 0, 16'd2);
        tbl[3]  = mk(0, 0, 1, 6'd10, 1, 6'd20, 6'd10, 32'h102,      1, 0, 16'd3);
        tbl[4]  = mk(0, 1, 0, 6'd0,  0, 6'd0,  6'd10, 32'h102,      0, 0, 16'd3);
        tbl[5]  = mk(0, 0, 0, 6'd0,  0, 6'd0,  6'd11, 32'h10A,      1, 0, 16'd4);
        tbl[6]  = mk(0, 0, 0, 6'd0,  0, 6'd0,  6'd12, 32'h10B,      1, 0, 16'd5);
        tbl[7]  = mk(0, 0, 0, 6'd0,  1, 6'd20, 6'd12, HALT,         0, 1, 16'd5);
        tbl[8]  = mk(0, 0, 0, 6'd0,  0, 6'd0,  6'd12, HALT,         0, 1, 16'd5);
        tbl[9]  = mk(1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  32'h0,        0, 0, 16'd0);
        tbl[10] = mk(1, 0, 0, 6'd0,  0, 6'd0,  6'd0,  32'h0,        0, 0, 16'd0);
        tbl[11] = mk(0, 0, 0, 6'd0,  1, 6'd20, 6'd20, 32'h100,      1, 0, 16'd1);
        tbl[12] = mk(0, 0, 0, 6'd0,  0, 6'd0,  6'd21, 32'h114,      1, 0, 16'd2);

        do_reset();
        check("reset_state", 6'd0, 32'h0, 0, 0, 16'd0);

        for (int i = 0; i < 13; i++) begin
            start_i = tbl[i].st; stall_i = tbl[i].sl; jmp_i = tbl[i].j;
            jmp_target_i = tbl[i].jt; br_taken_i = tbl[i].b; br_target_i = tbl[i].bt;
            @(posedge clk_i);
            #1;
            check($sformatf("vec%0d", i), tbl[i].e_ima, tbl[i].e_instr,
                  tbl[i].e_valid, tbl[i].e_halted, tbl[i].e_cnt);
        end

        // --- Sequential fetch up to a halt word at 6 ---
        for (int i = 0; i < 64; i++) mem[i] = 32'h100 + 32'(i);
        mem[6] = HALT;
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, "seq_start");
        for (int i = 0; i < 7; i++) cycle(0, 0, 0, 0, 0, 0, "seq_run");
        check("seq_end", 6'd6, HALT, 0, 1, 16'd6);

        // --- Stall with a held jump at PC=3 ---
        for (int i = 0; i < 64; i++) mem[i] = 32'h200 + 32'(i);
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, "stl_start");
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, "stl_pre");
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 1, 40, 0, 0, "stl_hold");
            check("stl_hold_abs", 6'd3, 32'h202, 0, 0, 16'd3);
        end
        cycle(0, 0, 1, 40, 0, 0, "stl_release");
        check("stl_release_abs", 6'd40, 32'h203, 1, 0, 16'd4);
        cycle(0, 0, 0, 0, 0, 0, "stl_after");

        // --- Wrap-around, then asynchronous reset at PC=17 ---
        for (int i = 0; i < 64; i++) mem[i] = 32'h300 + 32'(i);
        do_reset();
        cycle(1, 0, 0, 0, 0, 0, "wrap_start");
        for (int i = 0; i < 64; i++) cycle(0, 0, 0, 0, 0, 0, "wrap_run");
        check("wrap_pc0", 6'd0, 32'h33F, 1, 0, 16'd64);
        cycle(0, 0, 0, 0, 0, 0, "wrap_next");
        check("wrap_cnt65", 6'd1, 32'h300, 1, 0, 16'd65);
        for (int i = 0; i < 16; i++) cycle(0, 0, 0, 0, 0, 0, "to_pc17");
        check("at_pc17", 6'd17, 32'h310, 1, 0, 16'd81);
        #2;
        rst_ni = 0;
        model_reset();
        #1;
        check("async_reset", 6'd0, 32'h0, 0, 0, 16'd0);
        @(negedge clk_i);
        rst_ni = 1;
        #1;
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 0, 0, "post_rst_idle");
        check("post_rst_abs", 6'd0, 32'h0, 0, 0, 16'd0);
        cycle(1, 0, 0, 0, 0, 0, "post_rst_start");
        cycle(0, 0, 0, 0, 0, 0, "post_rst_issue");

        // --- Randomized run against the model ---
        for (int i = 0; i < 64; i++)
            mem[i] = ($urandom_range(0, 15) == 0) ? HALT : $urandom;
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cycle(($urandom_range(0, 5) == 0), ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 6) == 0), int'($urandom_range(0, 63)),
                  ($urandom_range(0, 6) == 0), int'($urandom_range(0, 63)), "rand");
            if ($urandom_range(0, 499) == 0)
                mem[$urandom_range(0, 63)] = $urandom;
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
